// File: rtl/spi_pkg.sv
// spi_pkg: command, area, register and state encodings shared by the SPI burst controller
package spi_pkg;
  typedef enum logic [7:0] {
    CMD_NOOP        = 8'h00,
    CMD_END         = 8'h01,
    CMD_READ        = 8'h02,
    CMD_WRITE       = 8'h03,
    CMD_ENABLE      = 8'h04,
    CMD_DISABLE     = 8'h05,
    CMD_BURST_READ  = 8'h06,
    CMD_BURST_WRITE = 8'h07,
    CMD_CLEAR       = 8'h08
  } cmd_e;
  typedef enum logic [1:0] {AREA_CTRL, AREA_CHAR, AREA_MASK, AREA_RESULT} area_e;
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_COUNT, S_RDATA, S_WDATA} state_e;
  localparam logic [5:0] REG_WORD_SIZE   = 6'd0;
  localparam logic [5:0] REG_RESULT_MASK = 6'd1;
  localparam logic [5:0] REG_STATUS      = 6'd2;
  localparam logic [5:0] REG_FIFO_COUNT  = 6'd3;
  localparam logic [7:0] FWD_MIN         = 8'h10;
endpackage

// File: rtl/spi_burst_controller_if.sv
// spi_burst_controller_if: SPI byte bus plus the command and result streams to the core
interface spi_burst_controller_if;
  logic       cs;
  logic [7:0] mosi;
  logic [7:0] miso;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tuser;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] s_axis_tdata;
  modport slave (
    input  cs, mosi, m_axis_tready, s_axis_tvalid, s_axis_tdata,
    output miso, m_axis_tvalid, m_axis_tdata, m_axis_tuser, s_axis_tready
  );
  modport master (
    output cs, mosi, m_axis_tready, s_axis_tvalid, s_axis_tdata,
    input  miso, m_axis_tvalid, m_axis_tdata, m_axis_tuser, s_axis_tready
  );
endinterface

// File: rtl/result_fifo.sv
// result_fifo: 8-bit result id FIFO with synchronous clear and occupancy count
module result_fifo #(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = mem[rp];
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/spi_burst_controller.sv
// spi_burst_controller: SPI byte-command register file, core stream forwarder and result FIFO reader
module spi_burst_controller
  import spi_pkg::*;
#(
  parameter int N_SLOTS      = 8,
  parameter int RESULT_DEPTH = 16
) (
  input  logic                 sclk,
  input  logic                 rst,
  spi_burst_controller_if.slave bus,
  output logic [7:0]           word_size,
  output logic [7:0]           result_mask,
  output logic [8*N_SLOTS-1:0] characters,
  output logic [8*N_SLOTS-1:0] masks,
  output logic                 aclk,
  output logic                 aresetn
);
  localparam int IW = $clog2(N_SLOTS);
  localparam int CW = $clog2(RESULT_DEPTH) + 1;
  state_e state;
  logic burst_q, write_q;
  logic [1:0] area_q, r_area;
  logic [5:0] idx_q, idx_inc, r_idx;
  logic [7:0] rem_q, miso_q, m_data, ctrl_val, rd_val, status, fifo_dout;
  logic [N_SLOTS-1:0][7:0] chars_q, masks_q;
  logic m_valid, m_user, overflow, stall;
  logic active, cmd_hit, fwd, beat_busy, rd_en, wr_en;
  logic fifo_push, fifo_pop, fifo_clear, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  assign aclk = sclk;
  assign characters = chars_q;
  assign masks = masks_q;
  assign bus.miso = miso_q;
  assign bus.m_axis_tvalid = m_valid;
  assign bus.m_axis_tdata = m_data;
  assign bus.m_axis_tuser = m_user;
  assign bus.s_axis_tready = !fifo_full;
  assign active = !bus.cs;
  assign cmd_hit = active && state == S_IDLE;
  assign fwd = cmd_hit && aresetn && (bus.mosi == CMD_END || bus.mosi >= FWD_MIN);
  assign beat_busy = m_valid && !bus.m_axis_tready;
  assign fifo_clear = cmd_hit && bus.mosi == CMD_CLEAR;
  assign fifo_push = bus.s_axis_tvalid && !fifo_full && !fifo_clear;
  // the address byte is decoded straight off mosi so a single READ can answer on that same edge
  assign r_area = state == S_ADDR ? bus.mosi[7:6] : area_q;
  assign r_idx = state == S_ADDR ? bus.mosi[5:0] : idx_q;
  assign rd_en = active && ((state == S_ADDR && !burst_q && !write_q) || (state == S_COUNT && !write_q) || state == S_RDATA);
  assign wr_en = active && state == S_WDATA;
  assign fifo_pop = rd_en && r_area == AREA_RESULT && !fifo_empty;
  assign idx_inc = area_q == AREA_RESULT ? idx_q : (idx_q + 6'd1) & 6'(N_SLOTS - 1);
  assign status = {overflow, stall, fifo_empty, fifo_full, 4'b0};
  assign ctrl_val = r_idx == REG_WORD_SIZE ? word_size :
                    r_idx == REG_RESULT_MASK ? result_mask :
                    r_idx == REG_STATUS ? status :
                    r_idx == REG_FIFO_COUNT ? 8'(fifo_count) : 8'h00;
  assign rd_val = r_area == AREA_CTRL ? ctrl_val :
                  r_area == AREA_CHAR ? chars_q[r_idx[IW-1:0]] :
                  r_area == AREA_MASK ? masks_q[r_idx[IW-1:0]] :
                  fifo_empty ? 8'h00 : fifo_dout;
  result_fifo #(.DEPTH(RESULT_DEPTH)) u_fifo (
    .clk(sclk), .rst(rst), .clear(fifo_clear), .push(fifo_push), .din(bus.s_axis_tdata),
    .pop(fifo_pop), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty), .count(fifo_count)
  );
  always_ff @(posedge sclk) begin
    if (rst) begin
      state <= S_IDLE;
      burst_q <= 1'b0;
      write_q <= 1'b0;
      area_q <= '0;
      idx_q <= '0;
      rem_q <= '0;
      miso_q <= '0;
      word_size <= '0;
      result_mask <= '0;
      chars_q <= '0;
      masks_q <= '0;
      aresetn <= 1'b0;
      m_valid <= 1'b0;
      m_data <= '0;
      m_user <= 1'b0;
      overflow <= 1'b0;
      stall <= 1'b0;
    end else begin
      if (m_valid && bus.m_axis_tready) m_valid <= 1'b0;
      if (fwd && beat_busy) stall <= 1'b1;
      if (fwd && !beat_busy) begin
        m_valid <= 1'b1;
        m_data <= bus.mosi;
        m_user <= bus.mosi == CMD_END;
      end
      if (bus.s_axis_tvalid && fifo_full) overflow <= 1'b1;
      if (fifo_clear) begin
        overflow <= 1'b0;
        stall <= 1'b0;
      end
      if (rd_en) miso_q <= rd_val;
      if (wr_en && area_q == AREA_CTRL && idx_q == REG_WORD_SIZE) word_size <= bus.mosi;
      if (wr_en && area_q == AREA_CTRL && idx_q == REG_RESULT_MASK) result_mask <= bus.mosi;
      if (wr_en && area_q == AREA_CHAR) chars_q[idx_q[IW-1:0]] <= bus.mosi;
      if (wr_en && area_q == AREA_MASK) masks_q[idx_q[IW-1:0]] <= bus.mosi;
      if (bus.cs) state <= S_IDLE;
      else case (state)
        S_IDLE: begin
          if (bus.mosi inside {CMD_READ, CMD_WRITE, CMD_BURST_READ, CMD_BURST_WRITE}) begin
            state <= S_ADDR;
            burst_q <= bus.mosi[2];
            write_q <= bus.mosi[0];
          end
          if (bus.mosi == CMD_ENABLE) aresetn <= 1'b1;
          if (bus.mosi == CMD_DISABLE) aresetn <= 1'b0;
        end
        S_ADDR: begin
          area_q <= bus.mosi[7:6];
          idx_q <= bus.mosi[5:0];
          rem_q <= '0;
          state <= burst_q ? S_COUNT : write_q ? S_WDATA : S_IDLE;
        end
        S_COUNT: begin
          // a burst read already delivered its first byte here, so RDATA owes n more
          rem_q <= write_q ? bus.mosi : bus.mosi - 8'd1;
          if (!write_q) idx_q <= idx_inc;
          state <= write_q ? S_WDATA : bus.mosi == 8'd0 ? S_IDLE : S_RDATA;
        end
        S_RDATA, S_WDATA: begin
          idx_q <= idx_inc;
          rem_q <= rem_q - 8'd1;
          if (rem_q == 8'd0) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: doc/spi_burst_controller.md
SPI_BURST_CONTROLLER -- requirements
Module: spi_burst_controller

Interface
REQ-001 SHALL have parameter N_SLOTS, default 8, meaning number of character/mask slots (power of 2, 2..32).
REQ-002 SHALL have parameter RESULT_DEPTH, default 16, meaning result FIFO entries (power of 2, 2..64).
REQ-003 SHALL have ports, clock and reset first:
- sclk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, synchronous, active-high.
- cs  in  1  byte strobe, active-low; one byte per sclk edge while low.
- mosi  in  8  command/address/data byte.
- miso  out  8  read data.
- word_size  out  8  search word length register.
- result_mask  out  8  result mask register.
- characters  out  8*N_SLOTS  slot i at [8i+7:8i].
- masks  out  8*N_SLOTS  slot i at [8i+7:8i].
- aclk  out  1  equals sclk.
- aresetn  out  1  core enable, active-low reset to core.
- m_axis_tvalid / m_axis_tready / m_axis_tdata[8] / m_axis_tuser  out/in/out/out  stream to core; tuser=1 marks END.
- s_axis_tvalid / s_axis_tready / s_axis_tdata[8]  in/out/in  result ids from core.

Function
REQ-004 SHALL decode commands in IDLE: 00 NOOP, 01 END, 02 READ, 03 WRITE, 04 ENABLE, 05 DISABLE, 06 BURST_READ, 07 BURST_WRITE, 08 CLEAR.
REQ-005 SHALL decode address byte as area=[7:6] (0 control, 1 char, 2 mask, 3 result) and index=[5:0], index taken modulo N_SLOTS for char/mask.
REQ-006 SHALL implement states IDLE, ADDR, COUNT, RDATA, WDATA; any state returns to IDLE on the edge where cs is high.
REQ-007 SHALL for READ: IDLE->ADDR; on the address byte load miso (1-cycle latency), return to IDLE.
REQ-008 SHALL for WRITE: IDLE->ADDR->WDATA; on the data byte update target, return to IDLE.
REQ-009 SHALL for bursts: ADDR->COUNT; count byte n transfers n+1 bytes (n=255 gives 256); BURST_READ loads first miso on the count byte, then one per RDATA byte; BURST_WRITE writes one per WDATA byte; index increments after each byte, wrapping at N_SLOTS; return to IDLE after byte n+1.
REQ-010 SHALL map control area: index 0 word_size (RW), 1 result_mask (RW), 2 status RO {overflow, stall, empty, full, 4'b0}, 3 FIFO count RO, other indices read 0x00 and ignore writes.
REQ-011 SHALL pop one result FIFO entry per result-area read byte without index increment; read when empty returns 0x00 and does not pop; writes to result area are ignored.
REQ-012 SHALL, in IDLE with aresetn=1, forward END as tdata=0x01, tuser=1, and any byte >=0x10 as tdata=byte, tuser=0; bytes 0x09-0x0F are ignored.
REQ-013 SHALL hold m_axis_tvalid/tdata/tuser stable until tready; a byte to forward while a beat is pending is dropped and sets sticky stall.
REQ-014 SHALL keep a pending beat valid across cs high and across DISABLE; ENABLE/DISABLE set/clear aresetn on the next edge.
REQ-015 SHALL drive s_axis_tready = !full; push on tvalid&&tready; tvalid while full sets sticky overflow.
REQ-016 SHALL on simultaneous push and pop keep count unchanged and data order intact.
REQ-017 SHALL on CLEAR empty the FIFO and clear overflow and stall in the same edge; a push coincident with CLEAR is discarded.

Reset
REQ-018 SHALL on rst: state IDLE, miso 0x00, word_size 0x00, result_mask 0x00, characters 0, masks 0, aresetn 0, m_axis_tvalid 0, m_axis_tdata 0x00, m_axis_tuser 0, FIFO empty, overflow 0, stall 0.
REQ-019 SHALL let rst mid-burst abort the transaction with no further register writes.

Structure
REQ-020 SHALL place command codes, area codes, control register indices and state encoding in shared package spi_pkg.
REQ-021 SHALL implement the result FIFO as sub-module result_fifo (parameter DEPTH, width 8, push/pop/full/empty/count).

Verification
REQ-022 SHALL cover: 03,41,'a' then 02,41 -> characters[15:8]=0x61, miso=0x61 one cycle after address byte.
REQ-023 SHALL cover: N_SLOTS=8, 07,46,03,11,22,33,44 -> slots 6,7,0,1 = 0x11,0x22,0x33,0x44 (wrap).
REQ-024 SHALL cover: 04 then 'x',01 with tready low two cycles -> one beat 0x78 held, 0x01 dropped, status stall=1.
REQ-025 SHALL cover: push 16 ids with RESULT_DEPTH=16, extra tvalid -> tready=0, overflow=1; 06,C0,0F -> ids in order, count 0, further read 0x00.
REQ-026 SHALL cover: rst asserted during BURST_WRITE after 2 bytes -> all registers at reset values, state IDLE.
REQ-027 SHALL cover: push and pop on same edge at count 5 -> count stays 5, FIFO order preserved.
